// File: rtl/card_dealer.sv
// Deck buffer and dealer: captures a shuffled deck one card per cycle, then serves cards
// in order on request, each decoded to its blackjack point value. One card per two cycles.
module card_dealer #(
  parameter int DECK_SIZE     = 52,
  parameter int ID_W          = 6,
  parameter int CUT_THRESHOLD = 15
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            load_valid_i,
  input  logic [ID_W-1:0] load_index_i,
  input  logic [ID_W-1:0] load_card_i,
  input  logic            load_done_i,
  input  logic            req_i,
  output logic            busy_o,
  output logic            card_valid_o,
  output logic [ID_W-1:0] card_id_o,
  output logic [3:0]      card_value_o,
  output logic            card_is_ace_o,
  output logic            card_bad_o,
  output logic [ID_W-1:0] cards_left_o,
  output logic            deck_empty_o,
  output logic            need_shuffle_o,
  output logic            req_err_o
);

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_READY, S_DEAL} state_t;

  localparam logic [ID_W-1:0] DECK  = ID_W'(DECK_SIZE);
  localparam logic [ID_W-1:0] CUT   = ID_W'(CUT_THRESHOLD);
  localparam logic [ID_W-1:0] RANKS = ID_W'(13);

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] left_q, left_d;
  logic [ID_W-1:0] rd_q;
  logic            rd_en;
  logic            commit;
  logic            req_err_q, req_err_d;
  logic            card_valid_q;
  logic [ID_W-1:0] card_id_q;
  logic [3:0]      card_value_q;
  logic            card_is_ace_q;
  logic            card_bad_q;

  logic [ID_W-1:0] mem_q [DECK_SIZE];

  logic [ID_W-1:0] rank;
  logic [3:0]      dec_val;
  logic            dec_ace;
  logic            dec_bad;

  // Deck storage is not reset; slots beyond the deck are silently dropped.
  always_ff @(posedge clock_i) begin
    if (!reset_i && load_valid_i && (load_index_i < DECK)) begin
      mem_q[load_index_i] <= load_card_i;
    end
    if (rd_en) begin
      rd_q <= mem_q[ptr_q];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    left_d    = left_q;
    rd_en     = 1'b0;
    commit    = 1'b0;
    req_err_d = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (load_valid_i) begin
          state_d = S_LOAD;
        end else if (req_i) begin
          req_err_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (load_done_i) begin
          state_d = S_READY;
          ptr_d   = '0;
          left_d  = DECK;
        end
      end
      S_READY: begin
        if (load_valid_i) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          left_d  = '0;
        end else if (req_i) begin
          if (left_q != '0) begin
            state_d = S_DEAL;
            rd_en   = 1'b1;
          end else begin
            req_err_d = 1'b1;
          end
        end
      end
      S_DEAL: begin
        // A reload during the read drops the pending card entirely.
        if (load_valid_i) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          left_d  = '0;
        end else begin
          state_d = S_READY;
          commit  = 1'b1;
          ptr_d   = ptr_q + ID_W'(1);
          left_d  = left_q - ID_W'(1);
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    rank    = rd_q % RANKS;
    dec_bad = (rd_q >= DECK);
    dec_ace = 1'b0;
    dec_val = 4'd0;
    if (!dec_bad) begin
      if (rank == '0) begin
        dec_val = 4'd1;
        dec_ace = 1'b1;
      end else if (rank < ID_W'(10)) begin
        dec_val = 4'(rank) + 4'd1;
      end else begin
        dec_val = 4'd10;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= S_EMPTY;
      ptr_q         <= '0;
      left_q        <= '0;
      req_err_q     <= 1'b0;
      card_valid_q  <= 1'b0;
      card_id_q     <= '0;
      card_value_q  <= '0;
      card_is_ace_q <= 1'b0;
      card_bad_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      left_q       <= left_d;
      req_err_q    <= req_err_d;
      card_valid_q <= commit;
      if (commit) begin
        card_id_q     <= rd_q;
        card_value_q  <= dec_val;
        card_is_ace_q <= dec_ace;
        card_bad_q    <= dec_bad;
      end
    end
  end

  assign busy_o         = (state_q == S_LOAD) || (state_q == S_DEAL);
  assign card_valid_o   = card_valid_q;
  assign card_id_o      = card_id_q;
  assign card_value_o   = card_value_q;
  assign card_is_ace_o  = card_is_ace_q;
  assign card_bad_o     = card_bad_q;
  assign cards_left_o   = left_q;
  assign deck_empty_o   = (state_q == S_READY) && (left_q == '0);
  assign need_shuffle_o = (left_q < CUT);
  assign req_err_o      = req_err_q;

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: directed sequence with randomized decks checked against a deck/position model.
module tb_card_dealer;
  localparam int N = 52;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_done = 1'b0;
  logic       req = 1'b0;
  logic [5:0] load_index = '0;
  logic [5:0] load_card = '0;
  logic       busy, card_valid, card_is_ace, card_bad, deck_empty, need_shuffle, req_err;
  logic [5:0] card_id, cards_left;
  logic [3:0] card_value;

  int total = 0;
  int bad = 0;
  int src[N];
  int mdeck[N];
  int mpos = 0;
  int mleft = 0;

  always #5 clk = ~clk;

  card_dealer dut (
    .clock_i(clk), .reset_i(rst),
    .load_valid_i(load_valid), .load_index_i(load_index), .load_card_i(load_card),
    .load_done_i(load_done), .req_i(req),
    .busy_o(busy), .card_valid_o(card_valid), .card_id_o(card_id),
    .card_value_o(card_value), .card_is_ace_o(card_is_ace), .card_bad_o(card_bad),
    .cards_left_o(cards_left), .deck_empty_o(deck_empty),
    .need_shuffle_o(need_shuffle), .req_err_o(req_err)
  );

  function automatic int pts(input int id);
    int r;
    if (id >= N) return 0;
    r = id % 13;
    if (r == 0) return 1;
    if (r <= 9) return r + 1;
    return 10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shuffle_src();
    for (int i = N - 1; i > 0; i--) begin
      int j = $urandom_range(i, 0);
      int t = src[i];
      src[i] = src[j];
      src[j] = t;
    end
  endtask

  // Writes src[] into the deck (optionally in random slot order, with an out-of-range write first);
  // the final write carries load_done.
  task automatic load_deck(input bit rand_slots, input bit junk);
    int order[N];
    for (int i = 0; i < N; i++) order[i] = i;
    if (rand_slots) begin
      for (int i = N - 1; i > 0; i--) begin
        int j = $urandom_range(i, 0);
        int t = order[i];
        order[i] = order[j];
        order[j] = t;
      end
    end
    if (junk) begin
      load_valid = 1'b1; load_index = 6'd55; load_card = 6'd7;
      step();
      chk("junk_busy", busy, 1);
    end
    for (int i = 0; i < N; i++) begin
      load_valid = 1'b1;
      load_index = 6'(order[i]);
      load_card  = 6'(src[order[i]]);
      load_done  = (i == N - 1);
      step();
      if (i == 0) begin
        chk("load_busy", busy, 1);
        chk("load_left", cards_left, 0);
      end
    end
    load_valid = 1'b0;
    load_done  = 1'b0;
    for (int i = 0; i < N; i++) mdeck[i] = src[i];
    mpos = 0;
    mleft = N;
    chk("loaded_left", cards_left, N);
    chk("loaded_busy", busy, 0);
    chk("loaded_need", need_shuffle, 0);
  endtask

  task automatic check_card(input string tag);
    int id = mdeck[mpos];
    chk({tag, "_valid"}, card_valid, 1);
    chk({tag, "_id"}, card_id, id);
    chk({tag, "_value"}, card_value, pts(id));
    chk({tag, "_ace"}, card_is_ace, (id < N) && (id % 13 == 0));
    chk({tag, "_bad"}, card_bad, id >= N);
    mpos++;
    mleft--;
  endtask

  task automatic deal_one(input string tag);
    req = 1'b1;
    step();
    req = 1'b0;
    chk({tag, "_dealbusy"}, busy, 1);
    chk({tag, "_early"}, card_valid, 0);
    step();
    check_card(tag);
    chk({tag, "_left"}, cards_left, mleft);
    chk({tag, "_need"}, need_shuffle, mleft < 15);
    chk({tag, "_empty"}, deck_empty, mleft == 0);
  endtask

  initial begin
    int pulses;
    int held_id;
    int ndeal;

    step(); step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", card_valid, 0);
    chk("rst_left", cards_left, 0);
    chk("rst_need", need_shuffle, 1);
    chk("rst_empty", deck_empty, 0);
    chk("rst_err", req_err, 0);
    chk("rst_id", card_id, 0);

    // Request with no deck
    req = 1'b1; step(); req = 1'b0;
    chk("empty_err", req_err, 1);
    chk("empty_valid", card_valid, 0);
    step();
    chk("empty_err_pulse", req_err, 0);

    // In-order deck, deal it all
    for (int i = 0; i < N; i++) src[i] = i;
    load_deck(1'b0, 1'b0);
    deal_one("first");
    step(); step();
    chk("hold_valid", card_valid, 0);
    chk("hold_id", card_id, 0);
    chk("hold_ace", card_is_ace, 1);
    for (int k = 1; k < N; k++) deal_one("seq");
    chk("exhaust_empty", deck_empty, 1);
    req = 1'b1; step(); req = 1'b0;
    chk("over_err", req_err, 1);
    chk("over_busy", busy, 0);
    step();
    chk("over_valid", card_valid, 0);
    chk("over_left", cards_left, 0);

    // Shuffled deck, random slot order, held request
    shuffle_src();
    load_deck(1'b1, 1'b0);
    pulses = 0;
    req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (card_valid === 1'b1) begin
        pulses++;
        check_card("held");
      end
    end
    req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (card_valid === 1'b1) begin
        pulses++;
        check_card("held_tail");
      end
    end
    chk("held_pulses", pulses, 5);
    chk("held_left", cards_left, mleft);
    ndeal = $urandom_range(10, 3);
    for (int k = 0; k < ndeal; k++) deal_one("rand");

    // Reload during DEAL
    shuffle_src();
    req = 1'b1; step(); req = 1'b0;
    load_valid = 1'b1; load_index = 6'd0; load_card = 6'(src[0]);
    step();
    load_valid = 1'b0;
    chk("abort_valid", card_valid, 0);
    chk("abort_busy", busy, 1);
    chk("abort_left", cards_left, 0);
    chk("abort_need", need_shuffle, 1);
    step();
    chk("abort_valid2", card_valid, 0);
    load_deck(1'b1, 1'b0);
    deal_one("resume");

    // Illegal id in slot 0 and an out-of-range slot write
    shuffle_src();
    src[0] = 60;
    load_deck(1'b1, 1'b1);
    deal_one("badid");
    held_id = mdeck[mpos];
    deal_one("after_bad");

    // Reset while a card is in flight
    req = 1'b1; step(); req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstdeal_valid", card_valid, 0);
    chk("rstdeal_busy", busy, 0);
    chk("rstdeal_left", cards_left, 0);
    chk("rstdeal_id", card_id, 0);
    step();
    chk("rstdeal_valid2", card_valid, 0);
    req = 1'b1; step(); req = 1'b0;
    chk("rstdeal_err", req_err, 1);
    if (held_id < 0) chk("unused", held_id, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
